vga_timing_out: RTL and testbench

Final output stage of the VGA path. Generates 640x480@60 raster timing (hpos/vpos, active, frame_start) that drives the pixel generators and the pixel_mux select logic upstream. Takes the muxed 6-bit RGB222 pixel back in, forces it to black during blanking, and registers it together with hsync/vsync so that colour and sync leave the chip aligned on the same clock edge. An internal delay line compensates the fixed latency of the upstream pixel path.

---
 rtl/vga_pkg.sv | 68 ++++++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_timing_out.sv | 132 +++++++++++++
 tb/tb_vga_timing_out.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA output stage.
// Holds the 640x480@60 default timing, derived totals and sync windows,
// the RGB222 pixel type, the colour-bar palette, and the record carried
// through the timing delay line.
// Optional feature macro: VGA_COLOR_BARS_EN (adds the bar index to the record).
package vga_pkg;

  // 640x480@60 default timing, in pixel ticks / lines
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_PIPE_LAT = 1;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

  // Sync windows are half-open: [start, end)
  localparam int VGA_HSYNC_START = VGA_H_ACTIVE + VGA_H_FP;          // 656
  localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC;     // 752
  localparam int VGA_VSYNC_START = VGA_V_ACTIVE + VGA_V_FP;          // 490
  localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC;     // 492

  // Pixel format {R[1:0],G[1:0],B[1:0]}
  typedef logic [5:0] rgb222_t;

  // Colour bars: eight vertical bars, 80 pixels wide
  localparam int VGA_BAR_WIDTH = 80;

  localparam rgb222_t BAR_COL_0 = 6'h00;
  localparam rgb222_t BAR_COL_1 = 6'h03;
  localparam rgb222_t BAR_COL_2 = 6'h0C;
  localparam rgb222_t BAR_COL_3 = 6'h0F;
  localparam rgb222_t BAR_COL_4 = 6'h30;
  localparam rgb222_t BAR_COL_5 = 6'h33;
  localparam rgb222_t BAR_COL_6 = 6'h3C;
  localparam rgb222_t BAR_COL_7 = 6'h3F;

  function automatic rgb222_t bar_colour(input logic [2:0] idx);
    rgb222_t col;
    case (idx)
      3'd0:    col = BAR_COL_0;
      3'd1:    col = BAR_COL_1;
      3'd2:    col = BAR_COL_2;
      3'd3:    col = BAR_COL_3;
      3'd4:    col = BAR_COL_4;
      3'd5:    col = BAR_COL_5;
      3'd6:    col = BAR_COL_6;
      default: col = BAR_COL_7;
    endcase
    return col;
  endfunction

  // Per-tick timing record delayed to line up with the upstream pixel path
  typedef struct packed {
`ifdef VGA_COLOR_BARS_EN
    logic [2:0] bar_idx;
`endif
    logic       active;
    logic       hsync_n;
    logic       vsync_n;
  } timing_tap_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: ena-gated shift register of DEPTH stages, WIDTH bits each.
// Every stage resets asynchronously to rst_val. DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    // Clock, reset and enable have no work to do without storage
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, ena, rst_val};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel tick; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: every stage is a flop and gets the reset value, so idle syncs
        // (high) and blanking, not stale data, drain out after reset release.
        for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
      end else if (ena) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: 640x480 raster timing generator and output register.
// Produces hpos/vpos/active/frame_start for the upstream pixel path, delays
// the sync/active decode by PIPE_LAT ticks to meet the returning pixel, and
// registers hsync, vsync and the blanked pixel on the same edge.
// Optional feature macro: VGA_COLOR_BARS_EN adds bars_en and a built-in
// eight-bar test pattern that replaces pixel_in when selected.
// Parameter sums (H_TOTAL, V_TOTAL) must stay within 10 bits.
module vga_timing_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIPE_LAT = VGA_PIPE_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
`ifdef VGA_COLOR_BARS_EN
  input  logic       bars_en,
`endif
  input  logic [5:0] pixel_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       active,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb_out
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync_n_raw;
  logic        vsync_n_raw;
  timing_tap_t tap_d;
  timing_tap_t tap_q;
  timing_tap_t tap_rst;
  rgb222_t     rgb_next;

  // Raster counters: hpos every tick, vpos on line wrap, both wrap together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ena) begin
      // NOTE: non-blocking assignments so both counters update from the
      // pre-edge values; the 799,524 -> 0,0 wrap happens in one tick.
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Undelayed decodes straight off the counters for the upstream path
  assign hpos        = h_cnt;
  assign vpos        = v_cnt;
  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign hsync_n_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_n_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  // Assemble the record entering the delay line and its idle (reset) value
  always_comb begin
    tap_d         = '0;
    tap_d.active  = active;
    tap_d.hsync_n = hsync_n_raw;
    tap_d.vsync_n = vsync_n_raw;
`ifdef VGA_COLOR_BARS_EN
    tap_d.bar_idx = 3'(h_cnt / 10'(VGA_BAR_WIDTH));
`endif
    tap_rst         = '0;
    tap_rst.hsync_n = 1'b1;
    tap_rst.vsync_n = 1'b1;
  end

  vga_delay_line #(
    .WIDTH($bits(timing_tap_t)),
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .rst_val(tap_rst),
    .d      (tap_d),
    .q      (tap_q)
  );

  // Pick the pixel for the output register; blanking always wins
  always_comb begin
    // NOTE: default first so every path assigns rgb_next and no latch forms.
    rgb_next = '0;
    if (tap_q.active) begin
`ifdef VGA_COLOR_BARS_EN
      rgb_next = bars_en ? bar_colour(tap_q.bar_idx) : pixel_in;
`else
      rgb_next = pixel_in;
`endif
    end
  end

  // Output register: colour and syncs leave on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else if (ena) begin
      hsync   <= tap_q.hsync_n;
      vsync   <= tap_q.vsync_n;
      rgb_out <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: randomized self-checking bench for vga_timing_out.
// Horizontal timing is the real 640x480 line; the vertical active area and
// porches are shortened so whole frames fit in a short run (sync widths kept).
module tb_vga_timing_out;

  localparam int LAT   = 1;
  localparam int HA    = 640;
  localparam int HFP   = 16;
  localparam int HS    = 96;
  localparam int HBP   = 48;
  localparam int VA    = 8;
  localparam int VFP   = 3;
  localparam int VS    = 2;
  localparam int VBP   = 3;
  localparam int HT    = HA + HFP + HS + HBP;   // 800
  localparam int VT    = VA + VFP + VS + VBP;   // 16
  localparam int FRAME = HT * VT;               // 12800
  localparam int HS_LO = HA + HFP;              // 656
  localparam int HS_HI = HS_LO + HS;            // 752
  localparam int VS_LO = VA + VFP;              // 11
  localparam int VS_HI = VS_LO + VS;            // 13

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena;
  logic       bars_en;
  logic [5:0] pixel_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       active;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [5:0] rgb_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIPE_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
`ifdef VGA_COLOR_BARS_EN
    .bars_en    (bars_en),
`endif
    .pixel_in   (pixel_in),
    .hpos       (hpos),
    .vpos       (vpos),
    .active     (active),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_out    (rgb_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the registered outputs must show for raster position pos,
  // with pix/bars being the inputs present on the tick the output is loaded.
  function automatic logic [7:0] expect_out(input int pos, input logic [5:0] pix, input logic bars);
    int         h;
    int         v;
    logic       act;
    logic       hs_n;
    logic       vs_n;
    logic [2:0] idx;
    logic [5:0] col;
    h    = pos % HT;
    v    = (pos / HT) % VT;
    act  = (h < HA) && (v < VA);
    hs_n = !((h >= HS_LO) && (h < HS_HI));
    vs_n = !((v >= VS_LO) && (v < VS_HI));
    idx  = 3'(h / 80);
    col  = bars ? {idx[2], idx[2], idx[1], idx[1], idx[0], idx[0]} : pix;
    return {hs_n, vs_n, act ? col : 6'd0};
  endfunction

  // Model state: ticks since reset release plus expected registered outputs
  int         m_n;
  logic       m_hs;
  logic       m_vs;
  logic [5:0] m_rgb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n   <= 0;
      m_hs  <= 1'b1;
      m_vs  <= 1'b1;
      m_rgb <= 6'd0;
    end else if (ena) begin
      if (m_n >= LAT) {m_hs, m_vs, m_rgb} <= expect_out(m_n - LAT, pixel_in, bars_en);
      m_n <= m_n + 1;
    end
  end

  // Compare every output on every falling edge, away from the active edge
  always @(negedge clk) begin
    check("hpos",        32'(hpos),        32'(m_n % HT));
    check("vpos",        32'(vpos),        32'((m_n / HT) % VT));
    check("active",      32'(active),      32'(((m_n % HT) < HA) && (((m_n / HT) % VT) < VA)));
    check("frame_start", 32'(frame_start), 32'((m_n % FRAME) == 0));
    check("hsync",       32'(hsync),       32'(m_hs));
    check("vsync",       32'(vsync),       32'(m_vs));
    check("rgb_out",     32'(rgb_out),     32'(m_rgb));
  end

  initial begin
    int  hs_fall = 0;
    int  hs_low  = 0;
    int  vs_fall = 0;
    int  vs_low  = 0;
    int  fs_cnt  = 0;
    int  guard;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;

    ena      = 1'b1;
    bars_en  = 1'b0;
    pixel_in = 6'h3F;

    // Reset held with ena high and a bright pixel: outputs stay at reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb",   32'(rgb_out),     32'h0);
    check("rst_hsync", 32'(hsync),       32'h1);
    check("rst_vsync", 32'(vsync),       32'h1);
    check("rst_hpos",  32'(hpos),        32'h0);
    check("rst_vpos",  32'(vpos),        32'h0);
    check("rst_fs",    32'(frame_start), 32'h1);

    // Two full frames, ena continuous; constant 2A in frame 1, random in frame 2
    pixel_in = 6'h2A;
    rst_n    = 1'b1;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(posedge clk);
      #1;
      if (prev_hs && !hsync && hs_fall == 0) hs_fall = c;
      if (!hsync && c < HT) hs_low++;
      if (prev_vs && !vsync && vs_fall == 0) vs_fall = c;
      if (!vsync && c <= FRAME) vs_low++;
      if (frame_start) fs_cnt++;
      prev_hs = hsync;
      prev_vs = vsync;
      if (c == 641) check("rgb_last_active", 32'(rgb_out), 32'h2A);
      if (c == 642) check("rgb_first_blank", 32'(rgb_out), 32'h0);
      if (c == 799) begin
        check("hpos_799", 32'(hpos), 32'd799);
        check("vpos_799", 32'(vpos), 32'd0);
      end
      if (c == 800) begin
        check("hpos_wrap", 32'(hpos), 32'd0);
        check("vpos_wrap", 32'(vpos), 32'd1);
      end
      pixel_in = (c < FRAME) ? 6'h2A : 6'($urandom);
    end
    check("hsync_fall_clk",  32'(hs_fall), 32'd658);
    check("hsync_low_width", 32'(hs_low),  32'd96);
    check("vsync_fall_clk",  32'(vs_fall), 32'd8802);
    check("vsync_low_width", 32'(vs_low),  32'd1600);
    check("frame_pulses",    32'(fs_cnt),  32'd2);

    // ena at 1-in-4 duty with random pixels; the model demands a hold between ticks
    for (int c = 0; c < 6000; c++) begin
      ena      = (c % 4) == 3;
      pixel_in = 6'($urandom);
      @(posedge clk);
      #1;
    end

    // Run to hpos=300 inside the vsync lines, then assert reset mid-frame
    ena   = 1'b1;
    guard = 0;
    while (!((m_n % HT) == 300 && ((m_n / HT) % VT) == VS_LO) && guard < 2 * FRAME) begin
      pixel_in = 6'($urandom);
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_reset_point", 32'(guard < 2 * FRAME), 32'h1);
    check("pre_rst_vsync_low", 32'(vsync), 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hsync", 32'(hsync),   32'h1);
    check("mid_rst_vsync", 32'(vsync),   32'h1);
    check("mid_rst_rgb",   32'(rgb_out), 32'h0);
    check("mid_rst_hpos",  32'(hpos),    32'h0);
    check("mid_rst_vpos",  32'(vpos),    32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Release and run randomized ena/pixels (and bars when built in)
    rst_n = 1'b1;
    for (int c = 0; c < 9000; c++) begin
      ena      = ($urandom % 8) != 0;
      pixel_in = 6'($urandom);
`ifdef VGA_COLOR_BARS_EN
      bars_en  = c >= 4000;
`endif
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
